evaluate_mg_collector: RTL
==========================

// Module: evaluate_mg_collector
// PURPOSE
//  Downstream of the per-term midgame evaluators (castling white/black, material, mobility, ...).
//  Each evaluator returns one signed term with its own valid pulse and latency.
//  This block collects one term per input lane after a start pulse and sums them with saturation.
//  It emits one midgame score per board, with a 1-cycle valid.
// PARAMETERS
//  EVAL_WIDTH  24  signed width of each term and of eval_mg
//  TERMS       4   number of input term lanes (2..16)
//  TIMEOUT     15  max COLLECT cycles before missing terms are forced to 0 (1..255)
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  synchronous reset, active-low (0 = reset)
//  start        in   1                  pulse; same cycle the board_valid goes to the evaluators
//  term_valid   in   TERMS              per-lane valid pulse
//  term_eval    in   TERMS*EVAL_WIDTH   lane i at [i*EVAL_WIDTH +: EVAL_WIDTH], signed
//  busy         out  1                  1 while state != IDLE
//  eval_mg      out  EVAL_WIDTH         signed saturated sum; held until the next result
//  eval_valid   out  1                  1-cycle pulse, eval_mg/timeout_err valid
//  timeout_err  out  1                  qualifies eval_valid: 1 = one or more lanes missing
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, captured mask=0, holding regs=0, timer=0.
//  Reset outputs: eval_mg=0, eval_valid=0, timeout_err=0, busy=0.
//  Reset wins over every other input and aborts any collection in progress; no eval_valid results.
//  States: IDLE -> COLLECT -> SUM -> IDLE.
//  IDLE:
//  - start=1: go to COLLECT; clear mask and holding regs; timer=TIMEOUT.
//  - term_valid is ignored in IDLE, including in the start cycle.
//  COLLECT:
//  - Lane i valid and mask[i]==0: capture term_eval lane i and set mask[i].
//  - Repeated valid on an already-captured lane is ignored (first capture wins).
//  - The timer decrements every COLLECT cycle.
//  - Completion uses the mask including this cycle's captures.
//    All bits set: go to SUM, to_flag=0.
//    Otherwise, if timer==1: go to SUM, to_flag=1; uncaptured lanes stay 0.
//  - start is ignored in COLLECT and SUM (busy=1).
//  SUM:
//  - Full-precision sum, width EVAL_WIDTH+$clog2(TERMS), signed.
//  - Saturate symmetrically to [-(2^(EVAL_WIDTH-1)-1), +(2^(EVAL_WIDTH-1)-1)], so negation is safe.
//  - At the next posedge: register eval_mg, eval_valid=1, timeout_err=to_flag; state=IDLE.
//  Latency:
//  - Last needed term_valid in cycle c: SUM in c+1; eval_valid=1 in c+2.
//  - Minimum from start in cycle s to eval_valid: s+3.
//  Back-to-back:
//  - start is accepted in the cycle eval_valid is high (state already IDLE).
//  - Throughput: one board per 3 cycles maximum.
//  Timeout example: start in s, no lanes arrive -> SUM in s+TIMEOUT+1, eval_valid in s+TIMEOUT+2.
//  eval_valid and timeout_err are 0 in every cycle except the result pulse.
// TESTING (EVAL_WIDTH=16, TERMS=4, TIMEOUT=15 unless noted)
//  1. start@0; lanes 0..3 = -10,+20,-30,+5, all valid @3 -> eval_valid@5, eval_mg=-15, timeout_err=0.
//  2. start@0; lane0@1=-40, lane1@4=+60, lane2@2=-20, lane3@6=+7 -> eval_valid@8, eval_mg=+7.
//     Lane0 repeat @3 with 999 is ignored.
//  3. Four lanes of +20000 -> eval_mg=+32767.
//     Four lanes of -20000 -> eval_mg=-32767 (not -32768).
//  4. start@0; only lanes 0,1 (=+3,+4) arrive @2 -> SUM@16, eval_valid@17, eval_mg=+7, timeout_err=1.
//  5. start held high during COLLECT is ignored.
//     Second start in the eval_valid cycle is accepted.
//     term_valid in IDLE/start cycle is not captured.
//     Back-to-back boards produce exactly two results.
//  6. reset=0 mid-COLLECT -> busy=0 next cycle, no eval_valid.
//     A fresh start then gives a result free of stale terms.

Source files
------------

// File: rtl/evaluate_mg_collector.sv
`default_nettype none
// ==========================================================================
// evaluate_mg_collector: gathers one signed midgame term per lane, saturating sum
// Revision: 1.0
// ==========================================================================
module evaluate_mg_collector #(
  parameter int EVAL_WIDTH = 24,
  parameter int TERMS      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [TERMS-1:0]            term_valid,
  input  logic [TERMS*EVAL_WIDTH-1:0] term_eval,
  output logic                        busy,
  output logic [EVAL_WIDTH-1:0]       eval_mg,
  output logic                        eval_valid,
  output logic                        timeout_err
);

  localparam int SUM_W = EVAL_WIDTH + $clog2(TERMS);
  localparam logic [7:0] TIMER_INIT = 8'(TIMEOUT);
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SUM     = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [TERMS-1:0]        mask, mask_nxt, capture;
  logic [EVAL_WIDTH-1:0]   lane [TERMS];
  logic [EVAL_WIDTH-1:0]   hold [TERMS];
  logic [7:0]              timer;
  logic                    to_flag, to_flag_nxt;
  logic signed [SUM_W-1:0] sum_full;
  logic [EVAL_WIDTH-1:0]   sum_sat;

  for (genvar g = 0; g < TERMS; g++) begin : g_lane
    assign lane[g] = term_eval[g*EVAL_WIDTH +: EVAL_WIDTH];
  end

  // Only first arrival per lane is taken; completion sees this cycle's captures.
  assign capture  = (state == COLLECT) ? (term_valid & ~mask) : '0;
  assign mask_nxt = mask | capture;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    to_flag_nxt = to_flag;
    case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        if (&mask_nxt) begin
          state_nxt   = SUM;
          to_flag_nxt = 1'b0;
        end else if (timer == 8'd1) begin
          state_nxt   = SUM;
          to_flag_nxt = 1'b1;
        end
      end
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Symmetric clamp keeps -eval_mg representable.
  always_comb begin
    sum_full = '0;
    for (int i = 0; i < TERMS; i++) begin
      sum_full = sum_full + {{(SUM_W-EVAL_WIDTH){hold[i][EVAL_WIDTH-1]}}, hold[i]};
    end
    if (sum_full > SAT_MAX)      sum_sat = SAT_MAX[EVAL_WIDTH-1:0];
    else if (sum_full < SAT_MIN) sum_sat = SAT_MIN[EVAL_WIDTH-1:0];
    else                         sum_sat = sum_full[EVAL_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mask        <= '0;
      timer       <= '0;
      to_flag     <= 1'b0;
      eval_mg     <= '0;
      eval_valid  <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < TERMS; i++) hold[i] <= '0;
    end else begin
      eval_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask  <= '0;
            timer <= TIMER_INIT;
            for (int i = 0; i < TERMS; i++) hold[i] <= '0;
          end
        end
        COLLECT: begin
          mask    <= mask_nxt;
          timer   <= timer - 8'd1;
          to_flag <= to_flag_nxt;
          for (int i = 0; i < TERMS; i++) begin
            if (capture[i]) hold[i] <= lane[i];
          end
        end
        SUM: begin
          eval_mg     <= sum_sat;
          eval_valid  <= 1'b1;
          timeout_err <= to_flag;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
